rv32_fetch: RTL and testbench

Instruction fetch stage of the rv32 pipeline, directly upstream of decode. It holds the architectural fetch PC and drives a single-outstanding, zero-latency-capable instruction bus. It applies static backward-taken/forward-not-taken branch prediction and JAL prediction, and delivers `{pc, instr, valid, exception, predicted}` through a stall/flush-controlled pipeline register. Trap and branch-mispredict redirects, bus wait states, misaligned fetches and bus faults are all handled here.

---
 rtl/rv32_fetch_if.sv | 24 ++
 rtl/rv32_fetch.sv | 124 ++++++++++++
 tb/tb_rv32_fetch.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32_fetch_if.sv
// rtl/rv32_fetch_if.sv - instruction bus between the fetch stage and instruction memory
interface rv32_fetch_if;
   logic        instr_read_out;
   logic [31:0] instr_address_out;
   logic [31:0] instr_read_value_in;
   logic        instr_ready_in;
   logic        instr_fault_in;

   modport master (
      output instr_read_out,
      output instr_address_out,
      input  instr_read_value_in,
      input  instr_ready_in,
      input  instr_fault_in
   );

   modport slave (
      input  instr_read_out,
      input  instr_address_out,
      output instr_read_value_in,
      output instr_ready_in,
      output instr_fault_in
   );
endinterface

// File: rtl/rv32_fetch.sv
// rtl/rv32_fetch.sv - rv32 fetch stage: PC, static prediction, redirects, output register
module rv32_fetch #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         stall_in,
   input  logic         flush_in,
   input  logic         trap_in,
   input  logic [31:0]  trap_pc_in,
   input  logic         branch_mispredicted_in,
   input  logic [31:0]  branch_pc_in,
   rv32_fetch_if.master bus,
   output logic         valid_out,
   output logic         exception_out,
   output logic [3:0]   exception_cause_out,
   output logic         branch_predicted_taken_out,
   output logic [31:0]  pc_out,
   output logic [31:0]  instr_out
);
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic {S_RUN, S_HALT} state_t;

   state_t      r_state, w_state_nxt;
   logic [31:0] r_pc, w_pc_nxt;
   logic        r_valid, r_exc, r_pred;
   logic [3:0]  r_cause;
   logic [31:0] r_pc_out, r_instr;

   logic        w_valid, w_exc, w_pred;
   logic [3:0]  w_cause;
   logic [31:0] w_instr;
   logic        w_aligned, w_redirect;
   logic [31:0] w_redirect_pc, w_rdata, w_imm_b, w_imm_j, w_pred_pc;
   logic        w_is_bt, w_is_jal;

   assign w_aligned     = (r_pc[1:0] == 2'b00);
   assign w_redirect    = trap_in | branch_mispredicted_in;
   assign w_redirect_pc = trap_in ? trap_pc_in : branch_pc_in;
   assign w_rdata       = bus.instr_read_value_in;

   assign bus.instr_read_out    = (r_state == S_RUN) && w_aligned;
   assign bus.instr_address_out = r_pc;

   // Backward conditional branches (sign bit set) and every JAL are predicted taken.
   assign w_imm_b   = {{20{w_rdata[31]}}, w_rdata[7], w_rdata[30:25], w_rdata[11:8], 1'b0};
   assign w_imm_j   = {{12{w_rdata[31]}}, w_rdata[19:12], w_rdata[20], w_rdata[30:21], 1'b0};
   assign w_is_bt   = (w_rdata[6:0] == 7'b1100011) && w_rdata[31];
   assign w_is_jal  = (w_rdata[6:0] == 7'b1101111);
   assign w_pred_pc = w_is_jal ? r_pc + w_imm_j :
                      w_is_bt  ? r_pc + w_imm_b : r_pc + 32'd4;

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_valid     = 1'b0;
      w_exc       = 1'b0;
      w_cause     = 4'd0;
      w_pred      = 1'b0;
      w_instr     = NOP;
      if (w_redirect) begin
         w_pc_nxt    = w_redirect_pc;
         w_state_nxt = S_RUN;
      end else if (r_state == S_RUN) begin
         if (!w_aligned) begin
            if (!stall_in) begin
               w_exc       = 1'b1;
               w_state_nxt = S_HALT;
            end
         end else if (bus.instr_ready_in && !stall_in) begin
            if (bus.instr_fault_in) begin
               w_exc       = 1'b1;
               w_cause     = 4'd1;
               w_state_nxt = S_HALT;
            end else begin
               w_valid  = 1'b1;
               w_instr  = w_rdata;
               w_pred   = w_is_bt | w_is_jal;
               w_pc_nxt = w_pred_pc;
            end
         end
      end
      // A flush only replaces what is written to the output register.
      if (flush_in) begin
         w_valid = 1'b0;
         w_exc   = 1'b0;
         w_cause = 4'd0;
         w_pred  = 1'b0;
         w_instr = NOP;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc     <= RESET_VECTOR;
         r_state  <= S_RUN;
         r_valid  <= 1'b0;
         r_exc    <= 1'b0;
         r_cause  <= 4'd0;
         r_pred   <= 1'b0;
         r_pc_out <= 32'd0;
         r_instr  <= NOP;
      end else begin
         r_pc    <= w_pc_nxt;
         r_state <= w_state_nxt;
         if (!stall_in) begin
            r_valid  <= w_valid;
            r_exc    <= w_exc;
            r_cause  <= w_cause;
            r_pred   <= w_pred;
            r_pc_out <= r_pc;
            r_instr  <= w_instr;
         end
      end
   end

   assign valid_out                  = r_valid;
   assign exception_out              = r_exc;
   assign exception_cause_out        = r_cause;
   assign branch_predicted_taken_out = r_pred;
   assign pc_out                     = r_pc_out;
   assign instr_out                  = r_instr;
endmodule

// File: tb/tb_rv32_fetch.sv
// tb/tb_rv32_fetch.sv - self-checking bench for rv32_fetch against a program-level model
module tb_rv32_fetch;
   localparam logic [31:0] RV  = 32'h0000_0100;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset = 1'b1, stall_in = 1'b0, flush_in = 1'b0;
   logic        trap_in = 1'b0, branch_mispredicted_in = 1'b0;
   logic [31:0] trap_pc_in = '0, branch_pc_in = '0;
   logic        valid_out, exception_out, branch_predicted_taken_out;
   logic [3:0]  exception_cause_out;
   logic [31:0] pc_out, instr_out;

   rv32_fetch_if bus ();

   rv32_fetch #(.RESET_VECTOR(RV)) dut (
      .clk                        (clk),
      .reset                      (reset),
      .stall_in                   (stall_in),
      .flush_in                   (flush_in),
      .trap_in                    (trap_in),
      .trap_pc_in                 (trap_pc_in),
      .branch_mispredicted_in     (branch_mispredicted_in),
      .branch_pc_in               (branch_pc_in),
      .bus                        (bus),
      .valid_out                  (valid_out),
      .exception_out              (exception_out),
      .exception_cause_out        (exception_cause_out),
      .branch_predicted_taken_out (branch_predicted_taken_out),
      .pc_out                     (pc_out),
      .instr_out                  (instr_out)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Program image: word, whether it is predicted taken, and the PC fetched after it.
   logic [31:0] mem_w [logic [31:0]];
   logic [31:0] mem_n [logic [31:0]];
   bit          mem_p [logic [31:0]];

   logic [31:0] m_pc = RV, m_pcout = '0, m_instr = NOP;
   bit          m_halt = 1'b0, m_valid = 1'b0, m_exc = 1'b0, m_pred = 1'b0;
   logic [3:0]  m_cause = '0;
   logic [32:0] obs_bus, exp_bus;

   function automatic logic [70:0] dut_vec();
      return {valid_out, exception_out, exception_cause_out, branch_predicted_taken_out, pc_out, instr_out};
   endfunction

   function automatic logic [70:0] mdl_vec();
      return {m_valid, m_exc, m_cause, m_pred, m_pcout, m_instr};
   endfunction

   task automatic put(input logic [31:0] a, input logic [31:0] w, input bit p, input logic [31:0] n);
      mem_w[a] = w;
      mem_p[a] = p;
      mem_n[a] = n;
   endtask

   task automatic put_addi(input logic [31:0] a);
      logic [11:0] im;
      im = 12'($urandom);
      put(a, {im, 5'd1, 3'b000, 5'd1, 7'b0010011}, 1'b0, a + 32'd4);
   endtask

   task automatic put_branch(input logic [31:0] a, input int off, input bit bne);
      logic [12:0] o;
      o = off[12:0];
      put(a, {o[12], o[10:5], 5'd2, 5'd1, bne ? 3'b001 : 3'b000, o[4:1], o[11], 7'b1100011},
          off < 0, off < 0 ? a + 32'(off) : a + 32'd4);
   endtask

   task automatic put_jal(input logic [31:0] a, input int off);
      logic [20:0] o;
      o = off[20:0];
      put(a, {o[20], o[10:1], o[11], o[19:12], 5'd1, 7'b1101111}, 1'b1, a + 32'(off));
   endtask

   task automatic gen(input logic [31:0] a);
      int k, off;
      logic [31:0] r;
      if (mem_w.exists(a)) return;
      k   = int'($urandom_range(0, 3));
      off = (int'($urandom_range(0, 32)) - 16) * 4;
      if ($urandom_range(0, 7) == 0) off += 2;
      r = $urandom;
      case (k)
         0:       put_addi(a);
         1:       put_branch(a, off, r[0]);
         2:       put_jal(a, off);
         default: put(a, {r[31:7], 7'b0110111}, 1'b0, a + 32'd4);
      endcase
   endtask

   task automatic m_bubble(input logic [31:0] p);
      m_valid = 1'b0; m_exc = 1'b0; m_cause = 4'd0; m_pred = 1'b0; m_pcout = p; m_instr = NOP;
   endtask

   // One clock: drive inputs, capture the bus before the edge, then advance the model.
   task automatic cyc(input bit rst, input bit st, input bit fl, input bit tr, input logic [31:0] tpc,
                      input bit bm, input logic [31:0] bpc, input bit rdy, input bit flt);
      logic [31:0] old_pc;
      reset = rst; stall_in = st; flush_in = fl;
      trap_in = tr; trap_pc_in = tpc; branch_mispredicted_in = bm; branch_pc_in = bpc;
      if (m_pc[1:0] == 2'b00) begin
         gen(m_pc);
         bus.instr_read_value_in = mem_w[m_pc];
      end else begin
         bus.instr_read_value_in = $urandom;
      end
      bus.instr_ready_in = rdy;
      bus.instr_fault_in = flt;
      #2;
      obs_bus = {bus.instr_read_out, bus.instr_address_out};
      exp_bus = {!m_halt && (m_pc[1:0] == 2'b00), m_pc};
      @(posedge clk);
      #1;
      old_pc = m_pc;
      if (rst) begin
         m_pc = RV; m_halt = 1'b0;
         m_bubble(32'd0);
      end else begin
         if (!st) m_bubble(old_pc);
         if (tr || bm) begin
            m_pc   = tr ? tpc : bpc;
            m_halt = 1'b0;
         end else if (!m_halt && old_pc[1:0] != 2'b00) begin
            if (!st) begin
               m_exc = 1'b1; m_cause = 4'd0; m_halt = 1'b1;
            end
         end else if (!m_halt && rdy && !st) begin
            if (flt) begin
               m_exc = 1'b1; m_cause = 4'd1; m_halt = 1'b1;
            end else begin
               m_valid = 1'b1;
               m_instr = mem_w[old_pc];
               m_pred  = mem_p[old_pc];
               m_pc    = mem_n[old_pc];
            end
         end
         if (fl && !st) m_bubble(old_pc);
      end
   endtask

   task automatic test_reset();
      logic [70:0] exp_rst;
      exp_rst = {1'b0, 1'b0, 4'd0, 1'b0, 32'd0, NOP};
      cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
      total += 1;
      if (dut_vec() !== exp_rst) begin
         bad += 1; $display("FAIL reset_out got=%h exp=%h", dut_vec(), exp_rst);
      end
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      total += 1;
      if (obs_bus !== {1'b1, RV}) begin
         bad += 1; $display("FAIL reset_first_req got=%h exp=%h", obs_bus, {1'b1, RV});
      end
      total += 1;
      if (dut_vec() !== mdl_vec()) begin
         bad += 1; $display("FAIL reset_bubble got=%h exp=%h", dut_vec(), mdl_vec());
      end
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 4; i++) put_addi(RV + 32'(4 * i));
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
         total += 1;
         if (obs_bus !== exp_bus) begin
            bad += 1; $display("FAIL seq_bus got=%h exp=%h", obs_bus, exp_bus);
         end
         total += 1;
         if (pc_out !== RV + 32'(4 * i) || valid_out !== 1'b1 || branch_predicted_taken_out !== 1'b0 ||
             dut_vec() !== mdl_vec()) begin
            bad += 1; $display("FAIL seq_out got=%h exp_pc=%h model=%h", dut_vec(), RV + 32'(4 * i), mdl_vec());
         end
      end
   endtask

   task automatic test_branch();
      logic [31:0] start [3] = '{32'h200, 32'h200, 32'h300};
      logic [31:0] nxt   [3] = '{32'h1F8, 32'h204, 32'h340};
      bit          pred  [3] = '{1'b1, 1'b0, 1'b1};
      for (int k = 0; k < 3; k++) begin
         case (k)
            0:       put_branch(32'h200, -8, 1'b0);
            1:       put_branch(32'h200, 16, 1'b1);
            default: put_jal(32'h300, 32'h40);
         endcase
         put_addi(nxt[k]);
         cyc(0, 0, 0, 0, 0, 1, start[k], 1, 0);
         total += 1;
         if (dut_vec() !== mdl_vec()) begin
            bad += 1; $display("FAIL br_redirect got=%h exp=%h", dut_vec(), mdl_vec());
         end
         cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
         total += 1;
         if (obs_bus !== {1'b1, start[k]} || pc_out !== start[k] || branch_predicted_taken_out !== pred[k] ||
             dut_vec() !== mdl_vec()) begin
            bad += 1; $display("FAIL br_pred k=%0d got=%h bus=%h exp_pc=%h exp_pred=%0d", k, dut_vec(), obs_bus, start[k], pred[k]);
         end
         cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
         total += 1;
         if (obs_bus !== {1'b1, nxt[k]} || pc_out !== nxt[k] || valid_out !== 1'b1 || dut_vec() !== mdl_vec()) begin
            bad += 1; $display("FAIL br_target k=%0d got=%h bus=%h exp=%h", k, dut_vec(), obs_bus, nxt[k]);
         end
      end
   endtask

   task automatic test_wait_stall();
      put_addi(32'h104);
      put_addi(32'h108);
      cyc(0, 0, 0, 0, 0, 1, 32'h104, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
         total += 1;
         if (obs_bus !== {1'b1, 32'h104} || valid_out !== 1'b0 || instr_out !== NOP || dut_vec() !== mdl_vec()) begin
            bad += 1; $display("FAIL wait_bubble got=%h bus=%h exp=%h", dut_vec(), obs_bus, mdl_vec());
         end
      end
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
      total += 1;
      if (pc_out !== 32'h104 || valid_out !== 1'b1 || dut_vec() !== mdl_vec()) begin
         bad += 1; $display("FAIL wait_deliver got=%h exp=%h", dut_vec(), mdl_vec());
      end
      for (int i = 0; i < 2; i++) begin
         cyc(0, 1, i == 1, 0, 0, 0, 0, 1, 0);
         total += 1;
         if (obs_bus !== {1'b1, 32'h108} || pc_out !== 32'h104 || valid_out !== 1'b1 || dut_vec() !== mdl_vec()) begin
            bad += 1; $display("FAIL stall_hold got=%h bus=%h exp=%h", dut_vec(), obs_bus, mdl_vec());
         end
      end
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
      total += 1;
      if (pc_out !== 32'h108 || valid_out !== 1'b1 || dut_vec() !== mdl_vec()) begin
         bad += 1; $display("FAIL stall_resume got=%h exp=%h", dut_vec(), mdl_vec());
      end
      cyc(0, 0, 1, 0, 0, 0, 0, 1, 0);
      total += 1;
      if (valid_out !== 1'b0 || instr_out !== NOP || dut_vec() !== mdl_vec()) begin
         bad += 1; $display("FAIL flush_bubble got=%h exp=%h", dut_vec(), mdl_vec());
      end
   endtask

   task automatic test_misaligned();
      logic [70:0] exp_exc, exp_bub;
      exp_exc = {1'b0, 1'b1, 4'd0, 1'b0, 32'h402, NOP};
      exp_bub = {1'b0, 1'b0, 4'd0, 1'b0, 32'h402, NOP};
      cyc(0, 0, 0, 0, 0, 1, 32'h402, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
      total += 1;
      if (obs_bus !== {1'b0, 32'h402} || dut_vec() !== exp_exc) begin
         bad += 1; $display("FAIL misalign_exc got=%h bus=%h exp=%h", dut_vec(), obs_bus, exp_exc);
      end
      for (int i = 0; i < 2; i++) begin
         cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
         total += 1;
         if (obs_bus !== {1'b0, 32'h402} || dut_vec() !== exp_bub) begin
            bad += 1; $display("FAIL misalign_halt got=%h bus=%h exp=%h", dut_vec(), obs_bus, exp_bub);
         end
      end
      put_addi(32'h80);
      cyc(0, 0, 0, 1, 32'h80, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
      total += 1;
      if (obs_bus !== {1'b1, 32'h80} || pc_out !== 32'h80 || valid_out !== 1'b1) begin
         bad += 1; $display("FAIL misalign_resume got=%h bus=%h exp_pc=00000080", dut_vec(), obs_bus);
      end
   endtask

   task automatic test_fault();
      logic [70:0] exp_exc;
      exp_exc = {1'b0, 1'b1, 4'd1, 1'b0, 32'h500, NOP};
      put_addi(32'h500);
      cyc(0, 0, 0, 0, 0, 1, 32'h500, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
      total += 1;
      if (obs_bus !== {1'b1, 32'h500} || dut_vec() !== exp_exc) begin
         bad += 1; $display("FAIL fault_exc got=%h bus=%h exp=%h", dut_vec(), obs_bus, exp_exc);
      end
      for (int i = 0; i < 2; i++) begin
         cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
         total += 1;
         if (obs_bus[32] !== 1'b0 || valid_out !== 1'b0 || dut_vec() !== mdl_vec()) begin
            bad += 1; $display("FAIL fault_halt got=%h bus=%h exp=%h", dut_vec(), obs_bus, mdl_vec());
         end
      end
      cyc(0, 0, 0, 1, 32'h80, 0, 0, 1, 0);
   endtask

   task automatic test_simultaneous();
      put_addi(32'h80);
      put_addi(32'h84);
      put_addi(32'h900);
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 32'h80, 1, 32'h900, 1, 0);
      total += 1;
      if (obs_bus !== {1'b1, 32'h84} || valid_out !== 1'b0 || dut_vec() !== mdl_vec()) begin
         bad += 1; $display("FAIL simul_discard got=%h bus=%h exp=%h", dut_vec(), obs_bus, mdl_vec());
      end
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      total += 1;
      if (obs_bus !== {1'b1, 32'h80}) begin
         bad += 1; $display("FAIL simul_trap_wins got=%h exp=%h", obs_bus, {1'b1, 32'h80});
      end
   endtask

   task automatic test_reset_mid();
      logic [70:0] exp_rst;
      exp_rst = {1'b0, 1'b0, 4'd0, 1'b0, 32'd0, NOP};
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      total += 1;
      if (dut_vec() !== exp_rst) begin
         bad += 1; $display("FAIL midreset_out got=%h exp=%h", dut_vec(), exp_rst);
      end
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      total += 1;
      if (obs_bus !== {1'b1, RV}) begin
         bad += 1; $display("FAIL midreset_addr got=%h exp=%h", obs_bus, {1'b1, RV});
      end
   endtask

   task automatic test_random();
      bit st, fl, tr, bm, rdy, flt;
      logic [31:0] tpc, bpc;
      for (int i = 0; i < 500; i++) begin
         st  = ($urandom_range(0, 5) == 0);
         fl  = ($urandom_range(0, 11) == 0);
         tr  = ($urandom_range(0, 29) == 0);
         bm  = ($urandom_range(0, 24) == 0);
         rdy = ($urandom_range(0, 3) != 0);
         flt = ($urandom_range(0, 39) == 0);
         tpc = 32'h1000 + 32'($urandom_range(0, 255) * 4) + (($urandom_range(0, 15) == 0) ? 32'd2 : 32'd0);
         bpc = 32'h2000 + 32'($urandom_range(0, 255) * 4) + (($urandom_range(0, 15) == 0) ? 32'd1 : 32'd0);
         cyc(0, st, fl, tr, tpc, bm, bpc, rdy, flt);
         total += 1;
         if (obs_bus !== exp_bus) begin
            bad += 1; $display("FAIL rand_bus i=%0d got=%h exp=%h", i, obs_bus, exp_bus);
         end
         total += 1;
         if (dut_vec() !== mdl_vec()) begin
            bad += 1; $display("FAIL rand_out i=%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
         end
      end
   endtask

   initial begin
      bus.instr_read_value_in = NOP;
      bus.instr_ready_in      = 1'b0;
      bus.instr_fault_in      = 1'b0;
      test_reset();
      test_sequential();
      test_branch();
      test_wait_stall();
      test_misaligned();
      test_fault();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
